// File: rtl/mmio_pkg.sv
// Shared constants for the memory-mapped RAM: default parameters, region codes
// and map offsets. Offsets are counted downward from the top word of the map.
package mmio_pkg;

    localparam int DEF_DW    = 8;
    localparam int DEF_AW    = 8;
    localparam int DEF_N_IN  = 7;
    localparam int DEF_N_OUT = 1;

    typedef enum logic [1:0] {
        RGN_RAM    = 2'd0,
        RGN_IN     = 2'd1,
        RGN_STATUS = 2'd2,
        RGN_OUT    = 2'd3
    } region_e;

    function automatic int unsigned in_base_off();
        return 0;
    endfunction

    function automatic int unsigned status_off(input int unsigned n_in);
        return n_in;
    endfunction

    function automatic int unsigned out_base_off(input int unsigned n_in);
        return n_in + 1;
    endfunction

endpackage

// File: rtl/mmio_in_port.sv
// One memory-mapped input port: optional two-flop synchroniser, sample register
// and sticky change-detect bit. Build with MMIO_RAM_INSYNC_EN to add the synchroniser.
module mmio_in_port #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] din,
    input  logic          clr,
    output logic [DW-1:0] sample,
    output logic          changed
);

    logic [DW-1:0] src;

`ifdef MMIO_RAM_INSYNC_EN
    logic [DW-1:0] sync1_reg;
    logic [DW-1:0] sync2_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= din;
            sync2_reg <= sync1_reg;
        end
    end

    assign src = sync2_reg;
`else
    assign src = din;
`endif

    logic [DW-1:0] sample_reg;
    logic          primed_reg;
    logic          chg_reg;

    // The first sample after reset only preloads; it never counts as a change.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sample_reg <= '0;
            primed_reg <= 1'b0;
            chg_reg    <= 1'b0;
        end else begin
            sample_reg <= src;
            primed_reg <= 1'b1;
            chg_reg    <= (chg_reg & ~clr) | (primed_reg && (src != sample_reg));
        end
    end

    assign sample  = sample_reg;
    assign changed = chg_reg;

endmodule

// File: rtl/mmio_ram.sv
// Single-port RAM with memory-mapped input ports, change-status register and
// output ports at the top of the map. MMIO_RAM_INSYNC_EN enables input synchronisers.
module mmio_ram
    import mmio_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int AW    = DEF_AW,
    parameter int N_IN  = DEF_N_IN,
    parameter int N_OUT = DEF_N_OUT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req,
    input  logic                we,
    input  logic [AW-1:0]       addr,
    input  logic [DW-1:0]       wdata,
    output logic [DW-1:0]       rdata,
    output logic                rvalid,
    output logic                err,
    input  logic [N_IN*DW-1:0]  in_data,
    output logic [N_OUT*DW-1:0] out_data,
    output logic                irq
);

    localparam int TOP       = (1 << AW) - 1;
    localparam int RAM_DEPTH = TOP - N_IN - N_OUT;
    localparam int RA        = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    logic [AW-1:0] off;
    region_e       region;
    logic          rd_fire;
    logic          wr_fire;
    logic [DW-1:0] in_sample [N_IN];
    logic [N_IN-1:0] chg;
    logic          status_clr;
    logic [DW-1:0] mmio_q_next;

    logic [DW-1:0] out_reg [N_OUT];
    logic [DW-1:0] mmio_q_reg;
    logic [DW-1:0] ram_q_reg;
    logic          sel_ram_reg;
    logic          rvalid_reg;
    logic          err_reg;
    logic [DW-1:0] mem [RAM_DEPTH];

    assign rd_fire    = rst_n && req && !we;
    assign wr_fire    = rst_n && req && we;
    assign off        = AW'(TOP) - addr;
    assign status_clr = rd_fire && (region == RGN_STATUS);

    always_comb begin
        region = RGN_RAM;
        if (off < AW'(in_base_off() + N_IN))
            region = RGN_IN;
        else if (off == AW'(status_off(N_IN)))
            region = RGN_STATUS;
        else if (off < AW'(out_base_off(N_IN) + N_OUT))
            region = RGN_OUT;
    end

    always_comb begin
        mmio_q_next = '0;
        case (region)
            RGN_IN: begin
                for (int k = 0; k < N_IN; k++)
                    if (off == AW'(in_base_off() + k)) mmio_q_next = in_sample[k];
            end
            RGN_STATUS: mmio_q_next = DW'(chg);
            RGN_OUT: begin
                for (int j = 0; j < N_OUT; j++)
                    if (off == AW'(out_base_off(N_IN) + j)) mmio_q_next = out_reg[j];
            end
            default: mmio_q_next = '0;
        endcase
    end

    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_in
            mmio_in_port #(.DW(DW)) u_port (
                .clk     (clk),
                .rst_n   (rst_n),
                .din     (in_data[gi*DW +: DW]),
                .clr     (status_clr),
                .sample  (in_sample[gi]),
                .changed (chg[gi])
            );
        end
        for (genvar gi = 0; gi < N_OUT; gi++) begin : g_out
            assign out_data[gi*DW +: DW] = out_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rvalid_reg  <= 1'b0;
            err_reg     <= 1'b0;
            mmio_q_reg  <= '0;
            sel_ram_reg <= 1'b0;
            for (int j = 0; j < N_OUT; j++) out_reg[j] <= '0;
        end else begin
            rvalid_reg <= rd_fire;
            err_reg    <= wr_fire && ((region == RGN_IN) || (region == RGN_STATUS));
            if (rd_fire) begin
                sel_ram_reg <= (region == RGN_RAM);
                mmio_q_reg  <= mmio_q_next;
            end
            for (int j = 0; j < N_OUT; j++)
                if (wr_fire && (region == RGN_OUT) && (off == AW'(out_base_off(N_IN) + j)))
                    out_reg[j] <= wdata;
        end
    end

    // RAM keeps its contents across reset; only the request gating sees rst_n.
    always_ff @(posedge clk) begin
        if (wr_fire && (region == RGN_RAM))
            mem[addr[RA-1:0]] <= wdata;
        if (rd_fire && (region == RGN_RAM))
            ram_q_reg <= mem[addr[RA-1:0]];
    end

    assign rdata  = sel_ram_reg ? ram_q_reg : mmio_q_reg;
    assign rvalid = rvalid_reg;
    assign err    = err_reg;
    assign irq    = |chg;

endmodule

// File: tb/tb_mmio_ram.sv
// Directed bench for mmio_ram with default parameters: a back-to-back vector
// table plus sequences for change detect, status clear and reset behaviour.
module tb_mmio_ram;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        rvalid;
    logic        err;
    logic [55:0] in_data;
    logic [7:0]  out_data;
    logic        irq;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       rvalid;
        logic       err;
        logic [7:0] rdata;
        logic [7:0] outd;
    } vec_t;

    localparam int NV = 17;
    vec_t vt [NV];

    mmio_ram dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .err      (err),
        .in_data  (in_data),
        .out_data (out_data),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d);
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
    endtask

    task automatic idle();
        req   = 1'b0;
        we    = 1'b0;
        addr  = 8'h00;
        wdata = 8'h00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{1'b1, 8'h10, 8'h5A, 1'b0, 1'b0, 8'h00, 8'h00};
        vt[1]  = '{1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h5A, 8'h00};
        vt[2]  = '{1'b1, 8'hF7, 8'hC3, 1'b0, 1'b0, 8'h00, 8'hC3};
        vt[3]  = '{1'b0, 8'hF7, 8'h00, 1'b1, 1'b0, 8'hC3, 8'hC3};
        vt[4]  = '{1'b1, 8'hF9, 8'h11, 1'b0, 1'b1, 8'h00, 8'hC3};
        vt[5]  = '{1'b1, 8'hF8, 8'h22, 1'b0, 1'b1, 8'h00, 8'hC3};
        vt[6]  = '{1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h5A, 8'hC3};
        vt[7]  = '{1'b0, 8'hF7, 8'h00, 1'b1, 1'b0, 8'hC3, 8'hC3};
        vt[8]  = '{1'b0, 8'hF8, 8'h00, 1'b1, 1'b0, 8'h00, 8'hC3};
        vt[9]  = '{1'b0, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 8'hC3};
        vt[10] = '{1'b1, 8'h00, 8'hA5, 1'b0, 1'b0, 8'h00, 8'hC3};
        vt[11] = '{1'b1, 8'h11, 8'h3C, 1'b0, 1'b0, 8'h00, 8'hC3};
        vt[12] = '{1'b1, 8'hF6, 8'h77, 1'b0, 1'b0, 8'h00, 8'hC3};
        vt[13] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'hA5, 8'hC3};
        vt[14] = '{1'b0, 8'h11, 8'h00, 1'b1, 1'b0, 8'h3C, 8'hC3};
        vt[15] = '{1'b0, 8'hF6, 8'h00, 1'b1, 1'b0, 8'h77, 8'hC3};
        vt[16] = '{1'b1, 8'hFF, 8'h99, 1'b0, 1'b1, 8'h00, 8'hC3};

        rst_n   = 1'b0;
        in_data = '0;
        idle();
        repeat (3) step();
        check("reset_rdata", rdata, 8'h00);
        check("reset_rvalid", rvalid, 1'b0);
        check("reset_err", err, 1'b0);
        check("reset_out", out_data, 8'h00);
        check("reset_irq", irq, 1'b0);
        $display("reset: rdata=%h rvalid=%b err=%b out=%h irq=%b", rdata, rvalid, err, out_data, irq);

        rst_n = 1'b1;
        step();

        // Back-to-back table: one request per cycle, result checked one cycle later.
        for (int i = 0; i < NV; i++) begin
            issue(vt[i].we, vt[i].addr, vt[i].wdata);
            step();
            $display("vec %0d: we=%b addr=%h wdata=%h -> rvalid=%b err=%b rdata=%h out=%h",
                     i, vt[i].we, vt[i].addr, vt[i].wdata, rvalid, err, rdata, out_data);
            check($sformatf("vec%0d_rvalid", i), rvalid, vt[i].rvalid);
            check($sformatf("vec%0d_err", i), err, vt[i].err);
            check($sformatf("vec%0d_out", i), out_data, vt[i].outd);
            if (vt[i].rvalid)
                check($sformatf("vec%0d_rdata", i), rdata, vt[i].rdata);
        end
        idle();
        step();
        check("err_single_pulse", err, 1'b0);
        check("idle_rvalid", rvalid, 1'b0);

        // Port 2 change sets irq; status read returns bit 2 and clears it.
        in_data[23:16] = 8'h01;
        repeat (3) step();
        check("chg2_irq", irq, 1'b1);
        issue(1'b0, 8'hF8, 8'h00);
        step();
        $display("status read: rvalid=%b rdata=%h irq=%b", rvalid, rdata, irq);
        check("chg2_status_rvalid", rvalid, 1'b1);
        check("chg2_status", rdata, 8'h04);
        check("chg2_irq_cleared", irq, 1'b0);
        issue(1'b0, 8'hF8, 8'h00);
        step();
        $display("status read: rvalid=%b rdata=%h irq=%b", rvalid, rdata, irq);
        check("chg2_status_again", rdata, 8'h00);
        issue(1'b0, 8'hFD, 8'h00);
        step();
        $display("port2 read: rvalid=%b rdata=%h irq=%b", rvalid, rdata, irq);
        check("port2_value", rdata, 8'h01);
        check("port2_read_no_irq", irq, 1'b0);

        // Port 0 changes in the same cycle as a status read.
        in_data[7:0] = 8'h01;
        issue(1'b0, 8'hF8, 8'h00);
        step();
        $display("status read with change: rvalid=%b rdata=%h irq=%b", rvalid, rdata, irq);
        check("race_status", rdata, 8'h00);
        check("race_irq_kept", irq, 1'b1);
        issue(1'b0, 8'hF8, 8'h00);
        step();
        $display("status read: rvalid=%b rdata=%h irq=%b", rvalid, rdata, irq);
        check("race_status_next", rdata, 8'h01);
        check("race_irq_cleared", irq, 1'b0);

        // Reset asserted together with a read: nothing returned, outputs cleared.
        issue(1'b1, 8'h20, 8'h99);
        step();
        rst_n = 1'b0;
        in_data[7:0] = 8'h55;
        issue(1'b0, 8'h20, 8'h00);
        step();
        $display("read under reset: rvalid=%b rdata=%h out=%h", rvalid, rdata, out_data);
        check("rst_read_rvalid", rvalid, 1'b0);
        check("rst_read_rdata", rdata, 8'h00);
        check("rst_out", out_data, 8'h00);
        idle();
        step();
        rst_n = 1'b1;
        step();
        step();
        check("post_rst_irq", irq, 1'b0);
        check("post_rst_rvalid", rvalid, 1'b0);
        issue(1'b0, 8'h20, 8'h00);
        step();
        $display("ram read after reset: rvalid=%b rdata=%h", rvalid, rdata);
        check("ram_kept_rvalid", rvalid, 1'b1);
        check("ram_kept", rdata, 8'h99);
        issue(1'b0, 8'hF8, 8'h00);
        step();
        $display("status after reset: rvalid=%b rdata=%h", rvalid, rdata);
        check("post_rst_status", rdata, 8'h00);
        issue(1'b0, 8'hFF, 8'h00);
        step();
        $display("port0 after reset: rvalid=%b rdata=%h", rvalid, rdata);
        check("post_rst_port0", rdata, 8'h55);
        issue(1'b0, 8'hF7, 8'h00);
        step();
        $display("out0 after reset: rvalid=%b rdata=%h", rvalid, rdata);
        check("post_rst_out_read", rdata, 8'h00);
        idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
